// File: rtl/md_unit_if.sv
// Bundle between the EX stage / hazard logic and md_unit.
// start is a request sampled only while busy is low; there is no ready
// signal, so the issuer must hold off while busy=1, and completion is
// signalled by a one-cycle done pulse coincident with valid hi/lo.
interface md_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        use_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbgState;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata, use_req,
    input  busy, stall, done, hi, lo, dbgState
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata, use_req,
    output busy, stall, done, hi, lo, dbgState
  );
endinterface

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO for the MIPS core.
// Define MD_FAST_MULT_EN to replace the iterative multiply with a one-cycle multiplier.
module md_unit (
  input logic       Clk,
  input logic       Reset,
  md_unit_if.slave  md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdState;

  mdState      state;
  mdState      stateNext;

  logic        opIsDiv;
  logic [63:0] acc;
  logic [31:0] operandB;
  logic [31:0] origA;
  logic [5:0]  iterCnt;
  logic        negQuot;
  logic        negRem;
  logic        divZero;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        doneReg;

  logic        signedOp;
  logic [31:0] magA;
  logic [31:0] magB;

  // Signed ops work on magnitudes; |0x80000000| is still 0x80000000 unsigned.
  assign signedOp = ~md.op[0];
  assign magA     = (signedOp && md.a[31]) ? (~md.a + 32'd1) : md.a;
  assign magB     = (signedOp && md.b[31]) ? (~md.b + 32'd1) : md.b;

`ifdef MD_FAST_MULT_EN
  logic [63:0] fastA;
  logic [63:0] fastB;
  logic [63:0] fastProd;

  // Low 64 bits of the extended product are correct for both signednesses.
  assign fastA    = md.op[0] ? {32'b0, md.a} : {{32{md.a[31]}}, md.a};
  assign fastB    = md.op[0] ? {32'b0, md.b} : {{32{md.b[31]}}, md.b};
  assign fastProd = fastA * fastB;
`endif

  // One shift-add multiply step on {P, multiplier}.
  logic [32:0] mulSum;
  logic [63:0] mulStep;

  assign mulSum  = {1'b0, acc[63:32]} + {1'b0, operandB};
  assign mulStep = acc[0] ? {mulSum, acc[31:1]} : {1'b0, acc[63:1]};

  // One restoring divide step on {R, Q}; the shifted remainder needs 33 bits.
  logic [63:0] divShift;
  logic [33:0] divDiff;
  logic        divOk;
  logic [63:0] divStep;

  assign divShift = {acc[62:0], 1'b0};
  assign divDiff  = {1'b0, acc[63:31]} - {2'b00, operandB};
  assign divOk    = ~|divDiff[33:32];
  assign divStep  = divOk ? {divDiff[31:0], acc[30:0], 1'b1} : divShift;

  // Sign fix-up applied in FIX.
  logic [63:0] prodFixed;
  logic [31:0] quotFixed;
  logic [31:0] remFixed;
  logic [63:0] resultHiLo;

  assign prodFixed = negQuot ? (~acc + 64'd1) : acc;
  assign quotFixed = negQuot ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign remFixed  = negRem ? (~acc[63:32] + 32'd1) : acc[63:32];

  always_comb begin
    resultHiLo = prodFixed;
    if (opIsDiv) begin
      if (divZero) begin
        resultHiLo = {origA, 32'hFFFF_FFFF};
      end else begin
        resultHiLo = {remFixed, quotFixed};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (md.start) begin
`ifdef MD_FAST_MULT_EN
          stateNext = md.op[1] ? CALC : FIX;
`else
          stateNext = CALC;
`endif
        end
      end
      CALC: begin
        if (iterCnt == 6'd31) begin
          stateNext = FIX;
        end
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      opIsDiv  <= 1'b0;
      acc      <= 64'd0;
      operandB <= 32'd0;
      origA    <= 32'd0;
      iterCnt  <= 6'd0;
      negQuot  <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
      hiReg    <= 32'd0;
      loReg    <= 32'd0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= (state == FIX);
      case (state)
        IDLE: begin
          if (md.hi_we) begin
            hiReg <= md.wdata;
          end
          if (md.lo_we) begin
            loReg <= md.wdata;
          end
          if (md.start) begin
            opIsDiv  <= md.op[1];
            acc      <= {32'd0, magA};
            operandB <= magB;
            origA    <= md.a;
            iterCnt  <= 6'd0;
            negQuot  <= signedOp & (md.a[31] ^ md.b[31]);
            negRem   <= signedOp & md.a[31];
            divZero  <= md.op[1] & (md.b == 32'd0);
`ifdef MD_FAST_MULT_EN
            if (!md.op[1]) begin
              acc     <= fastProd;
              negQuot <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          acc     <= opIsDiv ? divStep : mulStep;
          iterCnt <= iterCnt + 6'd1;
        end
        FIX: begin
          hiReg <= resultHiLo[63:32];
          loReg <= resultHiLo[31:0];
        end
        default: ;
      endcase
    end
  end

  assign md.busy     = (state != IDLE);
  assign md.stall    = md.busy & md.use_req;
  assign md.done     = doneReg;
  assign md.hi       = hiReg;
  assign md.lo       = loReg;
  assign md.dbgState = state;

endmodule
